grant_event_collector: RTL and testbench
========================================

// Module: grant_event_collector
// PURPOSE
//  Sits directly downstream of the 16-way output arbiter. The arbiter's one-hot grant also
//  drives the rd_en of the 16 spike FIFOs; this block captures the word the granted FIFO
//  returns. It tags the word with its source index and queues it as an event for the
//  controller over a valid/ready interface. It returns BUSY to the arbiter to throttle grants.
// PARAMETERS
//  N_SRC   16  number of source FIFOs / grant bits (fixed 16 in this revision)
//  DW      14  data width of each FIFO dout word
//  DEPTH   4   output queue depth in entries (power of 2, >=4)
//  TSW     16  timestamp width (used only with GEC_TIMESTAMP_EN)
// PORTS
//  CLK          in   1         system clock, rising edge
//  RST_N        in   1         asynchronous active-low reset
//  GRANT_IN     in   N_SRC     one-hot read strobe from arbiter (same net as FIFO rd_en)
//  FIFO_DOUT    in   N_SRC*DW  flattened FIFO outputs; word i at [DW*i+DW-1:DW*i]
//  EVT_VALID    out  1         queue head valid
//  EVT_READY    in   1         consumer accepts head when VALID&READY
//  EVT_DATA     out  DW        head data word
//  EVT_SRC      out  4         head source index 0..15
//  EVT_TS       out  TSW       head capture timestamp (GEC_TIMESTAMP_EN only)
//  BUSY         out  1         to arbiter AER_IN_BUSY: no room for another grant
//  GRANT_ERR    out  1         sticky: multi-hot GRANT_IN seen
//  OVF_ERR      out  1         sticky: capture dropped, queue full
// BEHAVIOUR
//  Reset: all outputs 0, queue empty, pointers/count 0, capture stage idle, sticky flags 0.
//  Stage 1 (cycle t, GRANT_IN!=0): register rd_pend=1 and src_idx = index of lowest set bit.
//   Multi-hot: lowest index wins, GRANT_ERR<=1 (sticky until reset). GRANT_IN==0: no action.
//  Stage 2 (cycle t+1, rd_pend): FIFO read data is valid this cycle. Select
//   FIFO_DOUT[src_idx], push {src_idx,data[,ts]} into the queue at the end of cycle t+1.
//  EVT_VALID rises in cycle t+2 when the queue was empty. Grant-to-valid latency = 2.
//  Queue: circular buffer, wr/rd pointers wrap modulo DEPTH, count width clog2(DEPTH)+1.
//   Pop on EVT_VALID&EVT_READY. EVT_DATA/SRC/TS show the head. Hold them stable while VALID&!READY.
//   Push and pop in the same cycle: count unchanged. This is legal even when full, because the pop
//   frees the slot first.
//   Push when full with no pop: the word is dropped, OVF_ERR<=1 (sticky), and the queue is unchanged.
//  BUSY = rd_pend | (count + in-flight >= DEPTH-1), registered-free combinational output.
//   The arbiter blocks re-grant for 2 cycles after a grant, so at most one capture is in flight.
//   Under a correct arbiter OVF_ERR never fires.
//  No grant during reset. Async reset mid-transfer discards the in-flight capture and the queue contents.
// CONFIGURATION
//  GEC_TIMESTAMP_EN defined: a free-running TSW-bit counter (reset 0, +1 per cycle, wraps)
//   is sampled in stage 2 and stored per entry. EVT_TS gives the capture cycle of the head.
//  Not defined: no counter and no storage. EVT_TS is tied to 0, and port width stays TSW.
// STRUCTURE
//  Shared package gec_pkg: GEC_NSRC=16, GEC_SRCW=4, GEC_DW=14.
//   It also holds function onehot_lowest_idx() and typedef of the queue entry {src,data,ts}.
//  One sub-module: gec_event_queue (parameterised sync circular FIFO with count, full, empty).
//  Top level: stage-1 encoder register, stage-2 mux and push, error flags, optional ts counter.
// TESTING
//  1 Single grant: GRANT_IN=16'h0008, FIFO3 word=14'h0ABC -> cycle t+2 VALID=1,
//    DATA=0ABC, SRC=3. READY=1 -> VALID=0 next cycle.
//  2 Back-pressure fill: READY=0, grants to 0,5,9 spaced 3 cycles -> BUSY=1 once count=3.
//    Drain order SRC 0,5,9 with their data. OVF_ERR stays 0.
//  3 Forced overflow: DEPTH=4, READY=0, grants ignoring BUSY until 5 pushes.
//    -> 5th word dropped, OVF_ERR=1, count=4, contents = first 4 words.
//  4 Multi-hot: GRANT_IN=16'h0120 -> SRC=5, FIFO5 data, GRANT_ERR=1, which persists until RST_N.
//  5 Push+pop when full: queue full, READY=1 and capture completes in the same cycle.
//    -> count stays 4, no OVF_ERR, wrap-around order preserved.
//  6 Reset mid-capture: RST_N low in cycle t+1 -> VALID=0 and BUSY=0 immediately, nothing queued.
//    With GEC_TIMESTAMP_EN: EVT_TS equals the counter value at capture.

Source files
------------

// File: rtl/gec_pkg.sv
// Shared widths, queue entry type and grant encoder for grant_event_collector.
// The entry carries a timestamp field only when GEC_TIMESTAMP_EN is defined.
package gec_pkg;

    localparam int GEC_NSRC = 16;
    localparam int GEC_SRCW = 4;
    localparam int GEC_DW   = 14;
    localparam int GEC_TSW  = 16;

    typedef struct packed {
        logic [GEC_SRCW-1:0] src;
        logic [GEC_DW-1:0]   data;
`ifdef GEC_TIMESTAMP_EN
        logic [GEC_TSW-1:0]  ts;
`endif
    } gec_entry_t;

    // If several bits are set, the lowest index wins.
    function automatic logic [GEC_SRCW-1:0] onehot_lowest_idx(input logic [GEC_NSRC-1:0] vec);
        logic [GEC_SRCW-1:0] idx;
        idx = '0;
        for (int i = GEC_NSRC - 1; i >= 0; i--) begin
            if (vec[i]) idx = GEC_SRCW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/gec_event_queue.sv
// Synchronous circular FIFO with occupancy count, full and empty flags.
// A push while full is accepted only when a pop in the same cycle frees the head slot.
module gec_event_queue #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr_en;
    logic          w_rd_en;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_rd_en = i_pop & ~o_empty;
    assign w_wr_en = i_push & (~o_full | w_rd_en);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/grant_event_collector.sv
// Captures the word returned by the granted spike FIFO, tags it with its source and queues it.
// Define GEC_TIMESTAMP_EN to add a free-running cycle counter stored with every event.
module grant_event_collector
    import gec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [GEC_NSRC-1:0]        i_grant,
    input  logic [GEC_NSRC*GEC_DW-1:0] i_fifo_dout,
    output logic                       o_evt_valid,
    input  logic                       i_evt_ready,
    output logic [GEC_DW-1:0]          o_evt_data,
    output logic [GEC_SRCW-1:0]        o_evt_src,
    output logic [GEC_TSW-1:0]         o_evt_ts,
    output logic                       o_busy,
    output logic                       o_grant_err,
    output logic                       o_ovf_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                r_rd_pend;
    logic [GEC_SRCW-1:0] r_src_idx;
    logic                r_grant_err;
    logic                r_ovf_err;

    logic                w_any_grant;
    logic                w_multi_hot;
    logic [GEC_DW-1:0]   w_sel_data;
    gec_entry_t          w_push_entry;
    gec_entry_t          w_head;
    logic [CW-1:0]       w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_drop;
    logic [CW:0]         w_occupancy;

    assign w_any_grant = |i_grant;
    assign w_multi_hot = |(i_grant & (i_grant - GEC_NSRC'(1)));

`ifdef GEC_TIMESTAMP_EN
    logic [GEC_TSW-1:0] r_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ts <= '0;
        else        r_ts <= r_ts + GEC_TSW'(1);
    end
`endif

    // Stage 1: the grant cycle is also the FIFO read strobe; remember which source was read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend   <= 1'b0;
            r_src_idx   <= '0;
            r_grant_err <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_rd_pend <= w_any_grant;
            if (w_any_grant) r_src_idx <= onehot_lowest_idx(i_grant);
            if (w_multi_hot) r_grant_err <= 1'b1;
            if (w_drop)      r_ovf_err   <= 1'b1;
        end
    end

    // Stage 2: FIFO read data is valid the cycle after the grant.
    always_comb begin
        w_sel_data        = i_fifo_dout[int'(r_src_idx)*GEC_DW +: GEC_DW];
        w_push_entry      = '0;
        w_push_entry.src  = r_src_idx;
        w_push_entry.data = w_sel_data;
`ifdef GEC_TIMESTAMP_EN
        w_push_entry.ts   = r_ts;
`endif
    end

    assign w_pop  = ~w_empty & i_evt_ready;
    assign w_drop = r_rd_pend & w_full & ~w_pop;

    gec_event_queue #(
        .W     ($bits(gec_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_rd_pend),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Leave room for the capture that may already be in flight.
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_rd_pend};
    assign o_busy      = r_rd_pend | (w_occupancy >= (CW+1)'(DEPTH - 1));

    assign o_evt_valid = ~w_empty;
    assign o_evt_data  = w_empty ? '0 : w_head.data;
    assign o_evt_src   = w_empty ? '0 : w_head.src;
`ifdef GEC_TIMESTAMP_EN
    assign o_evt_ts    = w_empty ? '0 : w_head.ts;
`else
    assign o_evt_ts    = '0;
`endif
    assign o_grant_err = r_grant_err;
    assign o_ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_grant_event_collector.sv
// Directed bench for grant_event_collector: capture latency, back-pressure, overflow,
// multi-hot grants, push+pop when full, asynchronous reset and the optional timestamp.
module tb_grant_event_collector;
    import gec_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [GEC_NSRC-1:0]        grant;
    logic [GEC_NSRC*GEC_DW-1:0] fifo_dout;
    logic                       evt_valid;
    logic                       evt_ready;
    logic [GEC_DW-1:0]          evt_data;
    logic [GEC_SRCW-1:0]        evt_src;
    logic [GEC_TSW-1:0]         evt_ts;
    logic                       busy;
    logic                       grant_err;
    logic                       ovf_err;

    int checks = 0;
    int errors = 0;
    logic [GEC_DW-1:0] words [GEC_NSRC];
    int ovf_srcs [5] = '{1, 2, 4, 6, 7};

    grant_event_collector #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_grant     (grant),
        .i_fifo_dout (fifo_dout),
        .o_evt_valid (evt_valid),
        .i_evt_ready (evt_ready),
        .o_evt_data  (evt_data),
        .o_evt_src   (evt_src),
        .o_evt_ts    (evt_ts),
        .o_busy      (busy),
        .o_grant_err (grant_err),
        .o_ovf_err   (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Grant for one cycle; returns one cycle later with the capture in stage 2.
    task automatic do_grant(input logic [GEC_NSRC-1:0] g);
        grant = g;
        step(1);
        grant = '0;
    endtask

    // Grant and wait until the captured word has been pushed.
    task automatic capture(input int src);
        do_grant(GEC_NSRC'(1) << src);
        step(1);
    endtask

    task automatic check_head(input string tag, input int src);
        check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check({tag, "_src"},   32'(evt_src),   32'(src));
        check({tag, "_data"},  32'(evt_data),  32'(words[src]));
    endtask

    initial begin
        for (int i = 0; i < GEC_NSRC; i++) words[i] = GEC_DW'(i * 32'h0123 + 32'h0011);
        words[3] = 14'h0ABC;
        for (int i = 0; i < GEC_NSRC; i++) fifo_dout[i*GEC_DW +: GEC_DW] = words[i];

        rst_n     = 1'b0;
        grant     = '0;
        evt_ready = 1'b0;
        step(2);
        check("rst_valid",     32'(evt_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_grant_err", 32'(grant_err), 32'd0);
        check("rst_ovf_err",   32'(ovf_err),   32'd0);
        check("rst_data",      32'(evt_data),  32'd0);
        check("rst_src",       32'(evt_src),   32'd0);
        rst_n = 1'b1;
        step(1);

        // Single grant: latency 2, pop on READY.
        do_grant(16'h0008);
        check("t1_valid_early", 32'(evt_valid), 32'd0);
        check("t1_busy_pend",   32'(busy),      32'd1);
        step(1);
        check("t1_valid", 32'(evt_valid), 32'd1);
        check("t1_data",  32'(evt_data),  32'h0ABC);
        check("t1_src",   32'(evt_src),   32'd3);
        evt_ready = 1'b1;
        step(1);
        check("t1_valid_popped", 32'(evt_valid), 32'd0);
        check("t1_busy_idle",    32'(busy),      32'd0);
        evt_ready = 1'b0;

        // Back-pressure fill: BUSY rises once three entries are held.
        capture(0);
        step(1);
        capture(5);
        check("t2_busy_cnt2", 32'(busy), 32'd0);
        step(1);
        capture(9);
        check("t2_busy_cnt3", 32'(busy), 32'd1);
        step(1);
        check_head("t2_hold", 0);
        evt_ready = 1'b1;
        check_head("t2_h0", 0);
        step(1);
        check_head("t2_h1", 5);
        step(1);
        check_head("t2_h2", 9);
        step(1);
        check("t2_empty",   32'(evt_valid), 32'd0);
        check("t2_ovf_err", 32'(ovf_err),   32'd0);
        evt_ready = 1'b0;

        // Forced overflow: fifth capture dropped.
        for (int k = 0; k < 5; k++) begin
            capture(ovf_srcs[k]);
            if (k == 3) check("t3_ovf_before", 32'(ovf_err), 32'd0);
            step(1);
        end
        check("t3_ovf_after", 32'(ovf_err), 32'd1);
        check("t3_busy_full", 32'(busy),    32'd1);
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_head($sformatf("t3_h%0d", k), ovf_srcs[k]);
            step(1);
        end
        check("t3_empty", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;

        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        check("rst2_ovf_err", 32'(ovf_err), 32'd0);

        // Multi-hot grant: lowest index wins, error is sticky.
        do_grant(16'h0120);
        check("t4_grant_err", 32'(grant_err), 32'd1);
        step(1);
        check_head("t4_head", 5);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check("t4_empty", 32'(evt_valid), 32'd0);
        step(2);
        check("t4_grant_err_sticky", 32'(grant_err), 32'd1);

        // Push and pop in the same cycle while full, across the pointer wrap.
        for (int s = 10; s < 14; s++) begin
            capture(s);
            step(1);
        end
        check("t5_busy_full", 32'(busy), 32'd1);
        check_head("t5_h10", 10);
        do_grant(GEC_NSRC'(1) << 14);
        evt_ready = 1'b1;
        step(1);
        check("t5_ovf_err", 32'(ovf_err), 32'd0);
        check("t5_busy",    32'(busy),    32'd1);
        check_head("t5_h11", 11);
        step(1);
        check_head("t5_h12", 12);
        step(1);
        check_head("t5_h13", 13);
        step(1);
        check_head("t5_h14", 14);
        step(1);
        check("t5_empty", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;

        // Reset while a capture is in stage 2 with one entry queued.
        capture(7);
        check_head("t6_pre", 7);
        do_grant(GEC_NSRC'(1) << 2);
        check("t6_busy_pend", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_valid_rst",     32'(evt_valid), 32'd0);
        check("t6_busy_rst",      32'(busy),      32'd0);
        check("t6_grant_err_rst", 32'(grant_err), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("t6_valid_after", 32'(evt_valid), 32'd0);
        check("t6_busy_after",  32'(busy),      32'd0);

        // Timestamp: counter is 0 after release, 1 during the capture stage.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        capture(4);
        check_head("t7_head", 4);
`ifdef GEC_TIMESTAMP_EN
        check("t7_ts", 32'(evt_ts), 32'd1);
`else
        check("t7_ts", 32'(evt_ts), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
